clusterv_mem_arb_2x1: RTL and testbench
=======================================

CLUSTERV_MEM_ARB_2X1 -- requirements
Module: clusterv_mem_arb_2x1

Interface
REQ-001 Parameters SHALL be:
  ADR_WIDTH, 32, address width.
  DAT_WIDTH, 32, data width.
  TIMEOUT, 255, maximum wait for ack/err (cycles, 1..65535).
REQ-002 Ports SHALL be (clock and reset first; one clock; reset synchronous, active-low):
  clock  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-low reset.
  i0_adr / i1_adr  in  ADR_WIDTH  initiator addresses.
  i0_dat_w / i1_dat_w  in  DAT_WIDTH  initiator write data.
  i0_dat_r / i1_dat_r  out  DAT_WIDTH  read data returned to each initiator.
  i0_cyc / i1_cyc  in  1  bus cycle request / lock.
  i0_stb / i1_stb  in  1  transfer strobe.
  i0_we / i1_we  in  1  write enable.
  i0_sel / i1_sel  in  DAT_WIDTH/8  byte selects.
  i0_ack / i1_ack  out  1  transfer acknowledge.
  i0_err / i1_err  out  1  transfer error.
  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel  out  as initiator  downstream Wishbone target port (feeds memory controller).
  t_dat_r  in  DAT_WIDTH; t_ack, t_err  in  1  target responses.

Function
REQ-003 FSM states SHALL be IDLE, GNT0, GNT1; state and a 1-bit last_grant register are the only arbitration state.
REQ-004 In IDLE, t_cyc and t_stb SHALL be 0 and t_adr/t_dat_w/t_we/t_sel SHALL be 0.
REQ-005 In IDLE, request n = in_cyc & in_stb; if exactly one request, move to GNTn next cycle.
REQ-006 In IDLE, if both request, grant the initiator not equal to last_grant (i1 when last_grant=0, i0 when last_grant=1).
REQ-007 In GNTn, t_cyc/t_stb/t_adr/t_dat_w/t_we/t_sel SHALL combinationally mirror initiator n; arbitration latency is exactly 1 cycle from request to t_stb.
REQ-008 In GNTn, t_ack and t_err SHALL route combinationally to in_ack/in_err of n only; the non-granted initiator's ack/err SHALL be 0.
REQ-009 i0_dat_r and i1_dat_r SHALL both equal t_dat_r at all times.
REQ-010 GNTn SHALL persist while in_cyc is 1 (bus lock, back-to-back transfers without re-arbitration); when in_cyc is 0, go to IDLE next cycle and set last_grant = n.
REQ-011 A wait counter SHALL clear on entry to GNTn and on any t_ack/t_err, and increment each GNTn cycle with in_stb=1 and no t_ack/t_err.
REQ-012 When the counter reaches TIMEOUT, that cycle SHALL assert in_err to n, force t_cyc/t_stb to 0, set last_grant = n, and go to IDLE.
REQ-013 Counter width SHALL be 16 bits; it SHALL saturate and never wrap.
REQ-014 If t_ack and t_err are both 1, err SHALL win; ack SHALL be suppressed.
REQ-015 An initiator dropping cyc mid-wait SHALL release the bus per REQ-010 with no err generated; any later t_ack SHALL be discarded.

Reset
REQ-016 When reset=0 at a clock edge: state=IDLE, last_grant=1 (so i0 wins first contention), counter=0.
REQ-017 During and after reset all outputs SHALL follow IDLE values (ack/err/t_cyc/t_stb = 0); reset mid-transfer SHALL abandon the transfer with no ack/err.

Verification
REQ-018 Single read: i0 cyc/stb, adr=0x0000_0100; target acks after 2 cycles with 0xDEAD_BEEF -> t_stb 1 cycle after request, i0_ack pulse with i0_dat_r=0xDEAD_BEEF, i1_ack=0.
REQ-019 Contention after reset: i0 and i1 request same cycle -> i0 granted first; after i0 drops cyc, i1 granted 1 cycle after IDLE; third simultaneous request grants i0.
REQ-020 Locked burst: i1 holds cyc for 4 acked writes, sel=4'b0011, while i0 requests -> i0 not granted until i1_cyc=0; all 4 writes reach target with sel=4'b0011.
REQ-021 Timeout: TIMEOUT=8, target never acks -> i0_err asserted exactly 8 cycles after grant, t_stb=0 that cycle, state IDLE next.
REQ-022 Reset mid-transfer: reset=0 while GNT1 with stb pending -> next cycle t_cyc=0, no ack/err to i1, following contention grants i0.
REQ-023 Simultaneous t_ack=1 and t_err=1 -> initiator sees err=1, ack=0.

Source files
------------

// File: rtl/clusterv_mem_arb_2x1.sv
// clusterv_mem_arb_2x1: two-initiator Wishbone arbiter with bus lock, round-robin tie-break and wait timeout
module clusterv_mem_arb_2x1 #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   i0_adr,
    input  logic [DAT_WIDTH-1:0]   i0_dat_w,
    output logic [DAT_WIDTH-1:0]   i0_dat_r,
    input  logic                   i0_cyc,
    input  logic                   i0_stb,
    input  logic                   i0_we,
    input  logic [DAT_WIDTH/8-1:0] i0_sel,
    output logic                   i0_ack,
    output logic                   i0_err,
    input  logic [ADR_WIDTH-1:0]   i1_adr,
    input  logic [DAT_WIDTH-1:0]   i1_dat_w,
    output logic [DAT_WIDTH-1:0]   i1_dat_r,
    input  logic                   i1_cyc,
    input  logic                   i1_stb,
    input  logic                   i1_we,
    input  logic [DAT_WIDTH/8-1:0] i1_sel,
    output logic                   i1_ack,
    output logic                   i1_err,
    output logic [ADR_WIDTH-1:0]   t_adr,
    output logic [DAT_WIDTH-1:0]   t_dat_w,
    output logic                   t_cyc,
    output logic                   t_stb,
    output logic                   t_we,
    output logic [DAT_WIDTH/8-1:0] t_sel,
    input  logic [DAT_WIDTH-1:0]   t_dat_r,
    input  logic                   t_ack,
    input  logic                   t_err
);
    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  GNT0      = 2'd1;
    localparam logic [1:0]  GNT1      = 2'd2;
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [1:0]  state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        req0, req1, own1, own_cyc, own_stb;
    logic        gnt0, gnt1, active, timeout;

    assign req0    = i0_cyc & i0_stb;
    assign req1    = i1_cyc & i1_stb;
    assign own1    = (state == GNT1);
    assign own_cyc = own1 ? i1_cyc : i0_cyc;
    assign own_stb = own1 ? i1_stb : i0_stb;
    // An asserted reset forces IDLE-looking outputs even before the clock edge lands.
    assign gnt0    = reset & (state == GNT0);
    assign gnt1    = reset & (state == GNT1);
    assign active  = gnt0 | gnt1;
    assign timeout = active & own_cyc & (wait_cnt >= TIMEOUT_W);

    assign t_cyc   = active & own_cyc & ~timeout;
    assign t_stb   = active & own_stb & ~timeout;
    assign t_adr   = gnt0 ? i0_adr   : gnt1 ? i1_adr   : '0;
    assign t_dat_w = gnt0 ? i0_dat_w : gnt1 ? i1_dat_w : '0;
    assign t_we    = gnt0 ? i0_we    : gnt1 ? i1_we    : 1'b0;
    assign t_sel   = gnt0 ? i0_sel   : gnt1 ? i1_sel   : '0;

    // Error beats ack; a timeout synthesises an error and hides any late ack.
    assign i0_ack   = gnt0 & t_ack & ~t_err & ~timeout;
    assign i1_ack   = gnt1 & t_ack & ~t_err & ~timeout;
    assign i0_err   = gnt0 & (t_err | timeout);
    assign i1_err   = gnt1 & (t_err | timeout);
    assign i0_dat_r = t_dat_r;
    assign i1_dat_r = t_dat_r;

    // Next arbitration state: grant from IDLE, hold while locked, release on cyc drop or timeout.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (req0 & req1)
                    state_nxt = last_grant ? GNT0 : GNT1;
                else if (req0)
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!own_cyc || timeout) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = own1;
                    wait_cnt_nxt   = '0;
                end else if (t_ack | t_err)
                    wait_cnt_nxt = '0;
                else if (own_stb && wait_cnt != CNT_MAX)
                    wait_cnt_nxt = wait_cnt + 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration registers; last_grant resets to 1 so initiator 0 wins first contention.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_clusterv_mem_arb_2x1.sv
// tb_clusterv_mem_arb_2x1: directed and random checks of the 2x1 arbiter against a behavioural model
module tb_clusterv_mem_arb_2x1;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i0_adr = '0, i1_adr = '0, i0_dat_w = '0, i1_dat_w = '0;
    logic [31:0] i0_dat_r, i1_dat_r, t_adr, t_dat_w, t_dat_r = '0;
    logic        i0_cyc = 0, i0_stb = 0, i0_we = 0, i1_cyc = 0, i1_stb = 0, i1_we = 0;
    logic [3:0]  i0_sel = '0, i1_sel = '0, t_sel;
    logic        i0_ack, i0_err, i1_ack, i1_err;
    logic        t_cyc, t_stb, t_we;
    logic        t_ack = 0, t_err = 0;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (-1 none), who was served last, cycles waited.
    int owner  = -1;
    bit last   = 1'b1;
    int waited = 0;

    logic        obs_cyc, obs_stb, obs_ack0, obs_ack1, obs_err0, obs_err1;
    logic [31:0] obs_adr, obs_dat0;
    logic [3:0]  obs_sel;

    always #5 clock = ~clock;

    clusterv_mem_arb_2x1 #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .i0_adr(i0_adr), .i0_dat_w(i0_dat_w), .i0_dat_r(i0_dat_r), .i0_cyc(i0_cyc),
        .i0_stb(i0_stb), .i0_we(i0_we), .i0_sel(i0_sel), .i0_ack(i0_ack), .i0_err(i0_err),
        .i1_adr(i1_adr), .i1_dat_w(i1_dat_w), .i1_dat_r(i1_dat_r), .i1_cyc(i1_cyc),
        .i1_stb(i1_stb), .i1_we(i1_we), .i1_sel(i1_sel), .i1_ack(i1_ack), .i1_err(i1_err),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we),
        .t_sel(t_sel), .t_dat_r(t_dat_r), .t_ack(t_ack), .t_err(t_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic c0, input logic s0, input logic c1, input logic s1);
        i0_cyc = c0; i0_stb = s0; i1_cyc = c1; i1_stb = s1;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic act, c, s, to, r0, r1;
        @(negedge clock);
        act = reset && owner >= 0;
        c   = (owner == 1) ? i1_cyc : i0_cyc;
        s   = (owner == 1) ? i1_stb : i0_stb;
        to  = act && c && waited >= TO;
        chk("t_cyc", {31'b0, t_cyc}, {31'b0, act && c && !to});
        chk("t_stb", {31'b0, t_stb}, {31'b0, act && s && !to});
        chk("t_adr", t_adr, !act ? 32'h0 : (owner == 1) ? i1_adr : i0_adr);
        chk("t_dat_w", t_dat_w, !act ? 32'h0 : (owner == 1) ? i1_dat_w : i0_dat_w);
        chk("t_we", {31'b0, t_we}, {31'b0, act && ((owner == 1) ? i1_we : i0_we)});
        chk("t_sel", {28'b0, t_sel}, {28'b0, !act ? 4'h0 : (owner == 1) ? i1_sel : i0_sel});
        chk("i0_ack", {31'b0, i0_ack}, {31'b0, act && owner == 0 && t_ack && !t_err && !to});
        chk("i1_ack", {31'b0, i1_ack}, {31'b0, act && owner == 1 && t_ack && !t_err && !to});
        chk("i0_err", {31'b0, i0_err}, {31'b0, act && owner == 0 && (t_err || to)});
        chk("i1_err", {31'b0, i1_err}, {31'b0, act && owner == 1 && (t_err || to)});
        chk("i0_dat_r", i0_dat_r, t_dat_r);
        chk("i1_dat_r", i1_dat_r, t_dat_r);
        obs_cyc = t_cyc; obs_stb = t_stb; obs_adr = t_adr; obs_sel = t_sel;
        obs_ack0 = i0_ack; obs_ack1 = i1_ack; obs_err0 = i0_err; obs_err1 = i1_err;
        obs_dat0 = i0_dat_r;
        @(posedge clock);
        r0 = i0_cyc && i0_stb;
        r1 = i1_cyc && i1_stb;
        if (!reset) begin
            owner = -1; last = 1'b1; waited = 0;
        end else if (owner < 0) begin
            if (r0 && r1) owner = last ? 0 : 1;
            else if (r0) owner = 0;
            else if (r1) owner = 1;
            waited = 0;
        end else if (!c || to) begin
            last = (owner == 1); owner = -1; waited = 0;
        end else if (t_ack || t_err)
            waited = 0;
        else if (s && waited < 65535)
            waited++;
        #1;
    endtask

    initial begin
        int n;
        bit seen;
        i0_sel = 4'hF;
        i1_sel = 4'hF;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();

        // Single read from i0 acked two cycles after grant.
        i0_adr = 32'h0000_0100;
        set_req(1, 1, 0, 0);
        cycle();
        cycle();
        chk("read_stb_latency", {31'b0, obs_stb}, 32'd1);
        cycle();
        t_ack = 1; t_dat_r = 32'hDEAD_BEEF;
        cycle();
        chk("read_ack", {31'b0, obs_ack0}, 32'd1);
        chk("read_data", obs_dat0, 32'hDEAD_BEEF);
        chk("read_no_i1_ack", {31'b0, obs_ack1}, 32'd0);
        t_ack = 0;
        set_req(0, 0, 0, 0);
        repeat (2) cycle();

        // Contention straight after reset.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        i0_adr = 32'hA000_0000;
        i1_adr = 32'hB000_0000;
        set_req(1, 1, 1, 1);
        cycle();
        cycle();
        chk("first_contention_i0", obs_adr, 32'hA000_0000);
        set_req(0, 0, 1, 1);
        cycle();
        cycle();
        chk("idle_gap_stb", {31'b0, obs_stb}, 32'd0);
        cycle();
        chk("then_i1", obs_adr, 32'hB000_0000);
        set_req(0, 0, 0, 0);
        cycle();
        set_req(1, 1, 1, 1);
        cycle();
        cycle();
        chk("third_contention_i0", obs_adr, 32'hA000_0000);
        set_req(0, 0, 0, 0);
        repeat (2) cycle();

        // Locked write burst from i1 while i0 waits.
        i1_we = 1; i1_sel = 4'b0011;
        set_req(1, 1, 1, 1);
        cycle();
        t_ack = 1;
        for (int k = 0; k < 4; k++) begin
            i1_adr = 32'h2000 + 32'(k * 4);
            i1_dat_w = $urandom();
            cycle();
            chk("burst_sel", {28'b0, obs_sel}, 32'h3);
            chk("burst_ack", {31'b0, obs_ack1}, 32'd1);
            chk("burst_i0_wait", {31'b0, obs_ack0}, 32'd0);
        end
        t_ack = 0;
        set_req(1, 1, 0, 0);
        i1_we = 0; i1_sel = 4'hF;
        cycle();
        cycle();
        cycle();
        chk("after_burst_i0", obs_adr, 32'hA000_0000);
        set_req(0, 0, 0, 0);
        repeat (2) cycle();

        // Target never answers: i0 times out.
        set_req(1, 1, 0, 0);
        cycle();
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (obs_err0) seen = 1;
            else if (obs_stb) n++;
        end
        chk("timeout_seen", {31'b0, seen}, 32'd1);
        chk("timeout_len", 32'(n), 32'(TO));
        chk("timeout_stb_low", {31'b0, obs_stb}, 32'd0);
        set_req(0, 0, 0, 0);
        cycle();
        chk("timeout_idle", {31'b0, obs_cyc}, 32'd0);

        // Reset while i1 has a pending strobe.
        set_req(0, 0, 1, 1);
        cycle();
        cycle();
        reset = 1'b0;
        t_ack = 1;
        set_req(1, 1, 1, 1);
        cycle();
        chk("reset_cyc", {31'b0, obs_cyc}, 32'd0);
        chk("reset_no_ack", {31'b0, obs_ack1}, 32'd0);
        chk("reset_no_err", {31'b0, obs_err1}, 32'd0);
        reset = 1'b1;
        t_ack = 0;
        cycle();
        cycle();
        chk("post_reset_i0", obs_adr, 32'hA000_0000);
        set_req(0, 0, 0, 0);
        repeat (2) cycle();

        // Ack and err together: err wins.
        set_req(1, 1, 0, 0);
        cycle();
        cycle();
        t_ack = 1; t_err = 1;
        cycle();
        chk("both_err", {31'b0, obs_err0}, 32'd1);
        chk("both_no_ack", {31'b0, obs_ack0}, 32'd0);
        t_ack = 0; t_err = 0;
        set_req(0, 0, 0, 0);
        repeat (2) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            i0_we = 1'($urandom()); i1_we = 1'($urandom());
            i0_adr = $urandom(); i1_adr = $urandom();
            i0_dat_w = $urandom(); i1_dat_w = $urandom();
            i0_sel = 4'($urandom()); i1_sel = 4'($urandom());
            t_dat_r = $urandom();
            t_ack = ($urandom_range(0, 9) < 2);
            t_err = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
